// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, functs, states and mux selects.
// The optional JAL instruction is enabled by defining MC_CONTROL_JAL_EN.
package mc_control_fsm_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'd0;
   localparam logic [5:0] OP_J      = 6'd2;
   localparam logic [5:0] OP_JAL    = 6'd3;
   localparam logic [5:0] OP_LW     = 6'd4;
   localparam logic [5:0] OP_SW     = 6'd5;
   localparam logic [5:0] OP_BEQ    = 6'd6;

   localparam logic [5:0] FUNCT_ADD = 6'd0;
   localparam logic [5:0] FUNCT_MAX = 6'd4;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_MEM_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {PC_ALU    = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2} pc_src_t;
   typedef enum logic [1:0] {SRCB_RT   = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2} alu_src_b_t;
   typedef enum logic [1:0] {DST_RT    = 2'd0, DST_RD    = 2'd1, DST_R31  = 2'd2} reg_dst_t;
   typedef enum logic [1:0] {WB_ALU    = 2'd0, WB_MEM    = 2'd1, WB_PC    = 2'd2} wb_src_t;

   function automatic logic funct_supported(input logic [5:0] funct);
      return funct <= FUNCT_MAX;
   endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for mc_control_fsm, driven by the latched opcode/funct.
// Opcode 3 (JAL) decodes to JUMP only when MC_CONTROL_JAL_EN is defined.
module mc_next_state
   import mc_control_fsm_pkg::*;
(
   input  logic [3:0] state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic [3:0] next_state
);

   state_t cur;
   state_t nxt;

   assign cur        = state_t'(state);
   assign next_state = nxt;

   // NOTE: the default assignment first keeps nxt driven on every path, so no latch is inferred.
   always_comb begin
      nxt = cur;
      case (cur)
         S_FETCH:    if (mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     nxt = S_EXEC_R;
               OP_LW, OP_SW: nxt = S_MEM_ADDR;
               OP_BEQ:       nxt = S_BRANCH;
               OP_J:         nxt = S_JUMP;
`ifdef MC_CONTROL_JAL_EN
               OP_JAL:       nxt = S_JUMP;
`endif
               default:      nxt = S_TRAP;
            endcase
         end
         S_EXEC_R:   nxt = funct_supported(funct) ? S_WB_R : S_TRAP;
         S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) nxt = S_WB_MEM;
         S_MEM_WR:   if (mem_ready) nxt = S_FETCH;
         S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: nxt = S_FETCH;
         S_TRAP:     nxt = S_TRAP;
         default:    nxt = S_TRAP;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: registered state, outputs decoded from the state plus mem_ready/zero_flag.
// Define MC_CONTROL_JAL_EN to support JAL (opcode 3); otherwise it traps.
module mc_control_fsm
   import mc_control_fsm_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int REGSIZE = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             mem_ready,
   input  logic             zero_flag,
   output logic [5:0]       alu_opcode,
   output logic [5:0]       alu_funct,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_src,
   output logic             illegal
);

   state_t     state_q;
   logic [3:0] next_state;
   logic [5:0] opcode_q;
   logic [5:0] funct_q;
   logic       unused_instr;

   if (WIDTH < 32 || REGSIZE < 1) begin : g_param_check
      $error("mc_control_fsm: WIDTH must be at least 32 and REGSIZE positive");
   end

   // Only the opcode and funct fields steer control; register fields go straight to the datapath.
   assign unused_instr = ^instr[25:6];

   mc_next_state u_next_state (
      .state      (state_q),
      .opcode     (opcode_q),
      .funct      (funct_q),
      .mem_ready  (mem_ready),
      .next_state (next_state)
   );

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         funct_q  <= '0;
      end else begin
         state_q <= state_t'(next_state);
         if (ir_write) begin
            opcode_q <= instr[31:26];
            funct_q  <= instr[5:0];
         end
      end
   end

   always_comb begin
      alu_opcode = OP_RTYPE;
      alu_funct  = FUNCT_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      reg_write  = 1'b0;
      reg_dst    = DST_RT;
      wb_src     = WB_ALU;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // A fetch completing while reset is held must not load IR or PC.
            if (mem_ready && !rst) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
            end
         end
         S_DECODE: alu_src_b = SRCB_IMM;
         S_EXEC_R: begin
            alu_funct = funct_q;
            alu_src_a = 1'b1;
         end
         S_WB_R: begin
            alu_funct = funct_q;
            alu_src_a = 1'b1;
            reg_write = 1'b1;
            reg_dst   = DST_RD;
         end
         S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
            alu_opcode = opcode_q;
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            mem_read   = (state_q == S_MEM_RD);
            mem_write  = (state_q == S_MEM_WR);
         end
         S_WB_MEM: begin
            reg_write = 1'b1;
            wb_src    = WB_MEM;
         end
         S_BRANCH: begin
            alu_opcode = OP_BEQ;
            alu_src_a  = 1'b1;
            pc_src     = PC_BRANCH;
            pc_en      = zero_flag;
         end
         S_JUMP: begin
            pc_en  = 1'b1;
            pc_src = PC_JUMP;
`ifdef MC_CONTROL_JAL_EN
            if (opcode_q == OP_JAL) begin
               reg_write = 1'b1;
               reg_dst   = DST_R31;
               wb_src    = WB_PC;
            end
`endif
         end
         S_TRAP:  illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
   end

endmodule
